lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one in-flight operation, handling passthrough, aligned loads/stores
// and illegal-access reporting towards a single-port memory and a writeback stage.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_addr,
  input  logic [31:0] i_in_wdata,
  input  logic [2:0]  i_in_funct3,
  input  logic        i_in_load,
  input  logic        i_in_store,
  input  logic [4:0]  i_in_rd,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wmask,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_data,
  output logic [4:0]  o_out_rd,
  output logic        o_out_wen,
  output logic        o_out_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_addr, r_wdata, r_out_data;
  logic [2:0]  r_funct3;
  logic        r_load, r_out_wen, r_out_err;
  logic [4:0]  r_out_rd;

  logic        w_accept, w_is_half, w_is_word, w_misalign;
  logic        w_bad_load, w_bad_store, w_illegal, w_mem_op, w_passthru;
  logic        w_in_req;
  logic [31:0] w_lanes, w_shift, w_load_data;
  logic [3:0]  w_mask;

  // Legality is decided at acceptance so only legal accesses ever reach the memory port.
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_is_half   = (i_in_funct3[1:0] == 2'b01);
  assign w_is_word   = (i_in_funct3 == 3'b010);
  assign w_misalign  = (w_is_half & i_in_addr[0]) | (w_is_word & (|i_in_addr[1:0]));
  assign w_bad_load  = i_in_load & ((i_in_funct3 == 3'b011) | (i_in_funct3 == 3'b110) |
                                    (i_in_funct3 == 3'b111));
  assign w_bad_store = i_in_store & (i_in_funct3[2] | (i_in_funct3[1:0] == 2'b11));
  assign w_illegal   = (i_in_load & i_in_store) | w_bad_load | w_bad_store |
                       ((i_in_load | i_in_store) & w_misalign);
  assign w_mem_op    = (i_in_load | i_in_store) & ~w_illegal;
  assign w_passthru  = ~i_in_load & ~i_in_store;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_accept)     w_state_next = w_mem_op ? StReq : StDone;
      StReq:  if (i_mem_gnt)    w_state_next = r_load ? StWait : StDone;
      StWait: if (i_mem_rvalid) w_state_next = StDone;
      StDone: if (i_out_ready)  w_state_next = StIdle;
      default:                  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_shift = i_mem_rdata >> {r_addr[1:0], 3'b000};
    unique case (r_funct3)
      3'b000:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_load_data = {24'h0, w_shift[7:0]};
      3'b101:  w_load_data = {16'h0, w_shift[15:0]};
      default: w_load_data = w_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_load     <= 1'b0;
      r_out_data <= '0;
      r_out_rd   <= '0;
      r_out_wen  <= 1'b0;
      r_out_err  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: if (w_accept) begin
          r_addr     <= i_in_addr;
          r_wdata    <= i_in_wdata;
          r_funct3   <= i_in_funct3;
          r_load     <= i_in_load;
          r_out_rd   <= i_in_rd;
          r_out_err  <= w_illegal;
          r_out_wen  <= w_passthru & (i_in_rd != 5'd0);
          r_out_data <= w_passthru ? i_in_addr : 32'h0;
        end
        StWait: if (i_mem_rvalid) begin
          r_out_data <= w_load_data;
          r_out_wen  <= (r_out_rd != 5'd0);
        end
        StDone: if (i_out_ready) begin
          r_out_wen <= 1'b0;
          r_out_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (r_funct3[1:0])
      2'b00: begin
        w_lanes = {4{r_wdata[7:0]}};
        w_mask  = 4'b0001 << r_addr[1:0];
      end
      2'b01: begin
        w_lanes = {2{r_wdata[15:0]}};
        w_mask  = 4'b0011 << r_addr[1:0];
      end
      default: begin
        w_lanes = r_wdata;
        w_mask  = 4'b1111;
      end
    endcase
  end

  // Memory outputs are zero outside REQ, which also covers the reset values.
  assign w_in_req    = (r_state == StReq);
  assign o_mem_req   = w_in_req;
  assign o_mem_we    = w_in_req & ~r_load;
  assign o_mem_addr  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign o_mem_wdata = o_mem_we ? w_lanes : 32'h0;
  assign o_mem_wmask = o_mem_we ? w_mask : 4'h0;

  assign o_in_ready  = (r_state == StIdle) & rst_n;
  assign o_out_valid = (r_state == StDone);
  assign o_out_data  = r_out_data;
  assign o_out_rd    = r_out_rd;
  assign o_out_wen   = r_out_wen & o_out_valid;
  assign o_out_err   = r_out_err & o_out_valid;

endmodule
